// File: rtl/mem_writer.sv
// Streaming word writer into a DEPTH-entry memory with a registered read port
// for the display scan chain. Define MEM_WRITER_FULL_STOP_EN to stall when full.
module mem_writer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   count,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL  = {1'b1, {ADDR_W{1'b0}}};

  // Handshake: a word transfers on a rising clk edge where wr_valid && wr_ready;
  // wr_data is only sampled then, and wr_valid may stay high while wr_ready is low.

  logic [0:0]        state;
  logic [ADDR_W-1:0] sa;
  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    wr_ready = 1'b0;
    if (state == ST_RUN) begin
`ifdef MEM_WRITER_FULL_STOP_EN
      wr_ready = !clear && (count != CNT_FULL);
`else
      wr_ready = !clear;
`endif
    end
  end

  assign busy   = (state == ST_CLEAR);
  assign accept = wr_valid && wr_ready;

  // The sweep and stream writes share the single memory write port.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wr_ptr;
    mem_wd = wr_data;
    if (state == ST_CLEAR) begin
      mem_we = 1'b1;
      mem_wa = sa;
      mem_wd = '0;
    end else if (accept) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_CLEAR;
      sa     <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          sa     <= sa + ADDR_ONE;
          wr_ptr <= '0;
          count  <= '0;
          if (sa == ADDR_LAST) state <= ST_RUN;
        end
        ST_RUN: begin
          if (clear) begin
            state  <= ST_CLEAR;
            sa     <= '0;
            wr_ptr <= '0;
            count  <= '0;
          end else if (accept) begin
            wr_ptr <= wr_ptr + ADDR_ONE;
            if (count != CNT_FULL) count <= count + CNT_ONE;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Array has no reset; the post-reset sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Read samples the pre-write contents, so same-address read/write returns old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_mem_writer.sv
// Directed bench for mem_writer: sweep, fill, clear priority, wrap or full-stop,
// asynchronous reset and read-before-write.
module tb_mem_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b1;
  logic        wr_ready;
  logic [15:0] wr_data = 16'hAAAA;
  logic        clear = 1'b0;
  logic [3:0]  rd_addr = 4'd0;
  logic [15:0] rd_data;
  logic [3:0]  wr_ptr;
  logic [4:0]  count;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_writer dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_ptr(wr_ptr), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge where CLEAR has just been entered with sa=0.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < 16; i++) begin
      check({tag, "_busy_hi"}, {31'd0, busy}, 32'd1);
      check({tag, "_ready_lo"}, {31'd0, wr_ready}, 32'd0);
      tick();
    end
    check({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
    rd_addr = a;
    tick();
    check(tag, {16'd0, rd_data}, {16'd0, exp});
  endtask

  task automatic push(input logic [15:0] d);
    int t;
    wr_valid = 1'b1;
    wr_data  = d;
    t = 0;
    while (!wr_ready && t < 100) begin
      tick();
      t++;
    end
    check("push_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // Reset values, checked while rst is high
    #3;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_ptr", {28'd0, wr_ptr}, 32'd0);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_rd", {16'd0, rd_data}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;

    // Post-reset sweep with wr_valid held high
    sweep_check("sweep0");
    check("sweep0_ready_hi", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b0;
    check("sweep0_ptr", {28'd0, wr_ptr}, 32'd0);
    check("sweep0_count", {27'd0, count}, 32'd0);
    for (int i = 0; i < 16; i++) read_check("sweep0_zero", 4'(i), 16'h0000);

    // Sequential fill 1..10; the write at addr 4 doubles as a read-before-write probe
    for (int i = 1; i <= 10; i++) begin
      if (i == 5) begin
        rd_addr = 4'd4;
        push(16'(i));
        check("rbw_old", {16'd0, rd_data}, 32'h0000);
      end else begin
        push(16'(i));
      end
    end
    check("fill_ptr", {28'd0, wr_ptr}, 32'd10);
    check("fill_count", {27'd0, count}, 32'd10);
    read_check("fill_rd3", 4'd3, 16'h0004);
    read_check("fill_rd4", 4'd4, 16'h0005);
    read_check("fill_rd9", 4'd9, 16'h000A);
    read_check("fill_rd10", 4'd10, 16'h0000);

    // Clear wins over a pending write; the held word lands after the sweep
    wr_valid = 1'b1;
    wr_data  = 16'h1234;
    clear    = 1'b1;
    #1;
    check("clr_ready_lo", {31'd0, wr_ready}, 32'd0);
    tick();
    clear = 1'b0;
    check("clr_count", {27'd0, count}, 32'd0);
    check("clr_ptr", {28'd0, wr_ptr}, 32'd0);
    sweep_check("sweep1");
    tick();
    wr_valid = 1'b0;
    check("held_ptr", {28'd0, wr_ptr}, 32'd1);
    check("held_count", {27'd0, count}, 32'd1);
    read_check("clr_rd10", 4'd10, 16'h0000);
    read_check("clr_rd3", 4'd3, 16'h0000);
    read_check("held_rd0", 4'd0, 16'h1234);

    // Wrap or full-stop with 17 words
    do_clear();
    sweep_check("sweep2");
    for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i));
`ifdef MEM_WRITER_FULL_STOP_EN
    check("full_ready_lo", {31'd0, wr_ready}, 32'd0);
    wr_valid = 1'b1;
    wr_data  = 16'h0110;
    repeat (3) tick();
    wr_valid = 1'b0;
    check("full_ptr", {28'd0, wr_ptr}, 32'd0);
    check("full_count", {27'd0, count}, 32'd16);
    read_check("full_rd0", 4'd0, 16'h0100);
    read_check("full_rd1", 4'd1, 16'h0101);
`else
    check("wrap_ready_hi", {31'd0, wr_ready}, 32'd1);
    check("wrap16_ptr", {28'd0, wr_ptr}, 32'd0);
    check("wrap16_count", {27'd0, count}, 32'd16);
    push(16'h0110);
    check("wrap_ptr", {28'd0, wr_ptr}, 32'd1);
    check("wrap_count", {27'd0, count}, 32'd16);
    read_check("wrap_rd0", 4'd0, 16'h0110);
    read_check("wrap_rd1", 4'd1, 16'h0101);
    read_check("wrap_rd15", 4'd15, 16'h010F);
`endif

    // Asynchronous reset mid-fill
    do_clear();
    sweep_check("sweep3");
    for (int i = 0; i < 5; i++) push(16'h0200 + 16'(i));
    check("mid_ptr", {28'd0, wr_ptr}, 32'd5);
    rd_addr = 4'd2;
    tick();
    check("mid_rd2", {16'd0, rd_data}, 32'h0202);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd1);
    check("arst_ready", {31'd0, wr_ready}, 32'd0);
    check("arst_ptr", {28'd0, wr_ptr}, 32'd0);
    check("arst_count", {27'd0, count}, 32'd0);
    check("arst_rd", {16'd0, rd_data}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    sweep_check("sweep4");
    for (int i = 0; i < 5; i++) read_check("arst_zero", 4'(i), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_writer.md
Name: mem_writer

Overview:
- Write-side counterpart to the sequential ROM-reader/display path.
- Accepts a stream of DATA_W-bit words over a valid/ready handshake and stores them in an internal DEPTH-entry memory at an auto-incrementing, wrapping write pointer.
- Exposes a registered random-access read port so the existing address-counter/display chain can scan it exactly as it scans the ROM: address in, q one clock later.
- Zero-sweeps its memory after reset and on a clear request.

Parameters:
- DATA_W, 16, word width; matches the display data bus.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W = 16 entries.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  producer has a word on wr_data.
- wr_ready  out  1  block can accept a word this cycle.
- wr_data  in  DATA_W  word to store.
- clear  in  1  request a zero-sweep of memory; sampled in RUN only.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- wr_ptr  out  ADDR_W  address the next accepted word is written to.
- count  out  ADDR_W+1  words held since the last sweep; saturates at DEPTH.
- busy  out  1  high while in CLEAR.

Behaviour:
- Reset (async, rst=1):
  - state=CLEAR, sweep address sa=0, wr_ptr=0, count=0, rd_data=0, busy=1, wr_ready=0.
  - Memory array is not reset directly; the sweep zeroes it.
- FSM has two states, CLEAR and RUN.
- CLEAR:
  - Each clk writes 0 to mem[sa], then sa<=sa+1.
  - When sa==DEPTH-1 the write occurs and the next state is RUN. The sweep takes exactly DEPTH cycles (16 by default).
  - wr_ready=0 and busy=1 throughout.
  - wr_ptr and count are held at 0.
  - The clear input is ignored.
- RUN:
  - busy=0.
  - wr_ready = !clear (combinational).
  - Accept = wr_valid && wr_ready. On accept:
    - mem[wr_ptr]<=wr_data.
    - wr_ptr<=wr_ptr+1, wrapping DEPTH-1 -> 0.
    - count<=count+1, saturating at DEPTH.
  - clear=1: next state CLEAR, sa<=0, wr_ptr<=0, count<=0. Any wr_valid in that cycle is not accepted, because wr_ready is low.
- Wrap-around (default build): after DEPTH accepts, wr_ptr returns to 0. Further accepts overwrite the oldest entries; count stays at DEPTH.
- Read port:
  - rd_data<=mem[rd_addr] every clk in every state; latency is 1 cycle.
  - Same-address read and write in one cycle returns the old contents (read-before-write).
  - During CLEAR, rd_data reflects the partially swept array.
- Handshake rule: wr_data is sampled only on accept. wr_valid may be held across cycles in which wr_ready is low, and no word is lost.
- Reset mid-operation: any state returns immediately to the reset values above and the sweep restarts from sa=0.

Optional Feature:
- Macro: MEM_WRITER_FULL_STOP_EN
- Defined:
  - In RUN, wr_ready = !clear && (count != DEPTH).
  - Once DEPTH words are held, writes stall and wr_ptr stays at 0 after the wrap. No overwrite occurs until clear or rst.
- Undefined: wrap-and-overwrite behaviour as specified above.

Test Plan:
- Post-reset sweep:
  - Pulse rst, then hold wr_valid=1 with wr_data=16'hAAAA.
  - Required: busy=1 and wr_ready=0 for exactly 16 clks, then busy=0, wr_ready=1.
  - Reading addresses 0..15 returns 16'h0000 with 1-cycle latency.
- Sequential fill:
  - Write 16'h0001..16'h000A, one word per clk.
  - Required: wr_ptr=10, count=10; rd_addr=3 gives rd_data=16'h0004 on the next clk.
- Backpressure and clear priority:
  - Hold wr_valid=1, wr_data=16'h1234, and assert clear in the same cycle.
  - Required: no accept, count=0 and wr_ptr=0 next clk, busy=1 for 16 clks, mem[old wr_ptr]=0.
- Wrap (default build):
  - Write 17 words 16'h0100..16'h0110.
  - Required: wr_ptr=1, count=16, mem[0]=16'h0110, mem[1]=16'h0101.
- Full stop (MEM_WRITER_FULL_STOP_EN defined):
  - Same 17 writes as the wrap test.
  - Required: wr_ready=0 after the 16th accept, mem[0]=16'h0100, wr_ptr=0, count=16.
- Async reset mid-fill:
  - Assert rst between clk edges after 5 writes.
  - Required: outputs reset immediately without waiting for a clk edge, then a full 16-cycle sweep.
  - Read-before-write check: rd_addr == wr_ptr during an accept returns the prior value.
